// File: rtl/dut_registro_ctrl_if.sv
// Configuration handshake between a requester and the DUT register controller.
// The requester presents a 24-bit word with cfg_valid; the controller takes it
// on a clk edge where cfg_valid and cfg_ready are both high.
interface dut_registro_ctrl_if;
  logic [23:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;

  // Requester side
  modport master (
    output cfg_data,
    output cfg_valid,
    input  cfg_ready
  );

  // Controller side
  modport slave (
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/dut_registro_ctrl.sv
// Serial loader for a 24-bit shift/latch control register on the DUT board.
// A word taken from the cfg handshake is shifted out LSB first on sdo with
// sclk, then transferred to the register outputs with one lclk pulse.
// Each sclk/lclk level lasts CLK_DIV clk cycles. en_n gates the register
// outputs and is held high while the latch pulse is in progress.
module dut_registro_ctrl #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  dut_registro_ctrl_if.slave        cfg,
  input  logic                      out_en,
  output logic                      sclk,
  output logic                      lclk,
  output logic                      sdo,
  output logic                      en_n,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH_HI,
    ST_LATCH_LO,
    ST_DONE
  } state_t;

  localparam logic [7:0] PH_LAST  = 8'(CLK_DIV - 1);
  localparam logic [4:0] BIT_LAST = 5'd23;

  state_t      state;
  logic [23:0] buffer;
  logic [4:0]  bit_cnt;
  logic [7:0]  phase_cnt;
  logic        ready_q;
  logic        loaded;
  logic        phase_last;

  assign phase_last    = (phase_cnt == PH_LAST);
  assign cfg.cfg_ready = ready_q;

  // Sequencer: state, counters, shift buffer and all registered outputs.
  // NOTE: every register here uses <= so all right-hand sides see the values
  // from before the edge; mixing in = would make the order of lines matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      // NOTE: the buffer is only a datapath register (no array), so clearing
      // it on reset is cheap and keeps sdo/debug views deterministic.
      buffer    <= '0;
      bit_cnt   <= '0;
      phase_cnt <= '0;
      ready_q   <= 1'b0;
      loaded    <= 1'b0;
      sclk      <= 1'b0;
      lclk      <= 1'b0;
      sdo       <= 1'b0;
      en_n      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      en_n <= ~(out_en & loaded);

      case (state)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (cfg.cfg_valid && ready_q) begin
            buffer    <= cfg.cfg_data;
            bit_cnt   <= '0;
            phase_cnt <= '0;
            sdo       <= cfg.cfg_data[0];
            ready_q   <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_SHIFT_LO;
          end
        end

        ST_SHIFT_LO: begin
          if (phase_last) begin
            phase_cnt <= '0;
            sclk      <= 1'b1;
            state     <= ST_SHIFT_HI;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end

        ST_SHIFT_HI: begin
          if (phase_last) begin
            phase_cnt <= '0;
            buffer    <= buffer >> 1;
            bit_cnt   <= bit_cnt + 5'd1;
            sclk      <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              // Last bit clocked in: blank outputs and pulse the latch.
              sdo   <= 1'b0;
              lclk  <= 1'b1;
              en_n  <= 1'b1;
              state <= ST_LATCH_HI;
            end else begin
              sdo   <= buffer[1];
              state <= ST_SHIFT_LO;
            end
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end

        ST_LATCH_HI: begin
          if (phase_last) begin
            phase_cnt <= '0;
            lclk      <= 1'b0;
            state     <= ST_LATCH_LO;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
            en_n      <= 1'b1;
          end
        end

        ST_LATCH_LO: begin
          if (phase_last) begin
            phase_cnt <= '0;
            done      <= 1'b1;
            loaded    <= 1'b1;
            state     <= ST_DONE;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end

        ST_DONE: begin
          ready_q <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
